sha1_stream_core: RTL and testbench
===================================

# sha1_stream_core

- Multi-block SHA-1 compression engine; the parametrised successor of the single-block hasher.
- Accepts a stream of pre-padded 512-bit message blocks over a valid/ready handshake and chains the intermediate hash across blocks.
- Computes a configurable number of rounds per clock.
- Sits between the message padder/buffer and any digest consumer, such as a compare unit or HMAC wrapper.

## Interface
Parameters:
- ROUNDS_PER_CYCLE, default 1: rounds evaluated per clock. Legal values are 1, 2, 4 and 5; any other value is an elaboration error.

Ports:
- Clocking and reset: one clock, CLK; reset RST is synchronous and active-high.
- CLK, input, 1: clock; all state updates on the rising edge.
- RST, input, 1: synchronous active-high reset.
- IN_VALID, input, 1: BLOCK_IN, IN_FIRST and IN_LAST are valid.
- IN_READY, output, 1: core can accept a block.
- IN_FIRST, input, 1: block starts a new message; chaining value is the IV.
- IN_LAST, input, 1: block ends the message; publish the digest.
- BLOCK_IN, input, 512: padded block. W[0] = BLOCK_IN[511:480], W[15] = BLOCK_IN[31:0], big-endian.
- IV_IN, input, 160: initial chaining value {H0..H4}. Present only with SHA1_IV_LOAD_EN.
- BUSY, output, 1: block in flight.
- DONE, output, 1: one-cycle pulse; DIGEST_OUT is newly valid.
- DIGEST_OUT, output, 160: {H0,H1,H2,H3,H4}, H0 in [159:128]. Holds its value until the next DONE.

## Operation
- States: IDLE, ROUND, FINAL.
- IDLE:
  - IN_READY=1, BUSY=0.
  - Accept on IN_VALID&&IN_READY:
    - Latch BLOCK_IN into a 16×32 rolling schedule register.
    - Latch IN_LAST.
    - If IN_FIRST, load H0..H4 from the IV; otherwise keep the current H (chaining).
    - Load A..E from the selected H.
    - Clear round counter t; go to ROUND.
- ROUND:
  - Each cycle applies R=ROUNDS_PER_CYCLE rounds t..t+R-1, then t+=R.
  - Round t uses the following f and K:
    - t 0–19: Ch(B,C,D)=(B&C)|(~B&D), K=5A827999.
    - t 20–39: Parity(B,C,D)=B^C^D, K=6ED9EBA1.
    - t 40–59: Maj(B,C,D)=(B&C)|(B&D)|(C&D), K=8F1BBCDC.
    - t 60–79: Parity(B,C,D)=B^C^D, K=CA62C1D6.
  - Round step: temp=rotl5(A)+f+E+K+W[t]; E=D; D=C; C=rotl30(B); B=A; A=temp.
  - W schedule:
    - Held as a 16-entry shift window; no 80-word array.
    - W[t]=rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]) for t≥16.
    - The window advances R words per cycle.
  - Go to FINAL after the cycle that completes t=79.
- FINAL:
  - Hi += the matching working variable, each mod 2^32 with carries discarded.
  - If the latched LAST=1: DIGEST_OUT takes the new H and DONE=1 for one cycle.
  - Go to IDLE.
- Chaining boundaries:
  - A block without IN_FIRST after a LAST chains from the published digest; this is the defined continuation behaviour.
  - IN_FIRST&&IN_LAST in one block is a single-block message.
- Inputs are ignored while IN_READY=0. BLOCK_IN may change after the accepting edge.
- Reset values:
  - IN_READY=0 during RST, 1 afterwards.
  - BUSY=0, DONE=0, DIGEST_OUT=0.
  - H=standard IV (67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0).
  - State=IDLE.
- RST mid-block aborts the computation. No DONE is produced and chaining state returns to the IV.

## Timing
- Accept edge is E0.
- ROUND occupies edges E1..E(80/R); FINAL update happens at edge E(80/R+1).
- DONE is high in the cycle after E(80/R+1): 81 cycles after accept for R=1, 17 for R=5.
- IN_READY rises together with DONE. The earliest next accept is at E(80/R+2).
- Throughput: one block per 80/R+2 cycles.
- BUSY=1 from the cycle after E0 through the FINAL cycle.
- Critical path: R chained adders/rotates. R=5 is for slow clocks only.

## Configuration
- Macro: SHA1_IV_LOAD_EN.
- Defined:
  - IV_IN port exists.
  - IN_FIRST loads H from IV_IN, sampled on the accept edge. This supports midstate resume and HMAC precomputed pads.
  - Reset still loads the standard IV.
- Undefined:
  - No IV_IN port.
  - IN_FIRST always loads the standard IV.

## Structure
- Package sha1_pkg contains:
  - K constants.
  - Standard IV.
  - rotl function.
  - f-select function indexed by round number.
  - State enum.
- Sub-module sha1_round:
  - Combinational, one round: inputs A..E, W and t; outputs the next A..E.
  - Instantiated ROUNDS_PER_CYCLE times in a chain.
- Top level holds the FSM, counter, W window, H registers and handshake.

## Test plan
- "abc" padded single block (FIRST=LAST=1), R=1 -> DIGEST_OUT=a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d; DONE exactly 81 cycles after accept.
- Empty-message padded block -> da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (block 1 FIRST, block 2 LAST), back-to-back IN_VALID:
  - Only one DONE, carrying 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
  - IN_READY=0 throughout processing.
- Repeat the first three cases with R=2, 4 and 5 -> identical digests; latencies 41, 21 and 17.
- RST asserted at round 40 of a block, then "abc" -> no DONE from the aborted block; correct "abc" digest follows.
- With SHA1_IV_LOAD_EN: run block 1 of the two-block vector, capture H via IN_LAST=1, then submit block 2 with IN_FIRST=1, IV_IN=captured H -> 84983e44… digest.

Source files
------------

// File: rtl/sha1_pkg.sv
// sha1_pkg: shared definitions for the SHA-1 stream core.
//   - round constants K0..K3 and the standard initial chaining value
//   - rotl(): 32-bit rotate left
//   - k_sel() / f_sel(): round constant and boolean function chosen by round number
//   - state_e: controller states of sha1_stream_core
package sha1_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StFinal
  } state_e;

  localparam logic [31:0] K0 = 32'h5A827999;
  localparam logic [31:0] K1 = 32'h6ED9EBA1;
  localparam logic [31:0] K2 = 32'h8F1BBCDC;
  localparam logic [31:0] K3 = 32'hCA62C1D6;

  localparam logic [159:0] StdIv = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                    32'h10325476, 32'hC3D2E1F0};

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    rotl = (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] k_sel(input logic [6:0] t);
    if (t < 7'd20) begin
      k_sel = K0;
    end else if (t < 7'd40) begin
      k_sel = K1;
    end else if (t < 7'd60) begin
      k_sel = K2;
    end else begin
      k_sel = K3;
    end
  endfunction

  function automatic logic [31:0] f_sel(input logic [6:0]  t,
                                        input logic [31:0] b,
                                        input logic [31:0] c,
                                        input logic [31:0] d);
    if (t < 7'd20) begin
      f_sel = (b & c) | (~b & d);
    end else if (t < 7'd40) begin
      f_sel = b ^ c ^ d;
    end else if (t < 7'd60) begin
      f_sel = (b & c) | (b & d) | (c & d);
    end else begin
      f_sel = b ^ c ^ d;
    end
  endfunction

endpackage

// File: rtl/sha1_round.sv
// sha1_round: one combinational SHA-1 round.
// Ports:
//   a_i..e_i : working variables entering the round
//   w_i      : schedule word W[t]
//   t_i      : round number 0..79 (selects f and K)
//   a_o..e_o : working variables after the round
module sha1_round
  import sha1_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] e_i,
  input  logic [31:0] w_i,
  input  logic [6:0]  t_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o,
  output logic [31:0] e_o
);

  logic [31:0] temp;

  assign temp = rotl(a_i, 5) + f_sel(t_i, b_i, c_i, d_i) + e_i + k_sel(t_i) + w_i;

  assign a_o = temp;
  assign b_o = a_i;
  assign c_o = rotl(b_i, 30);
  assign d_o = c_i;
  assign e_o = d_i;

endmodule

// File: rtl/sha1_stream_core.sv
// sha1_stream_core: multi-block SHA-1 compression engine with chaining across blocks.
// Accepts pre-padded 512-bit blocks over a valid/ready handshake and evaluates
// ROUNDS_PER_CYCLE rounds per clock (legal: 1, 2, 4, 5).
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   IN_VALID/IN_READY   : block handshake
//   IN_FIRST, IN_LAST   : message start (load IV) / message end (publish digest)
//   BLOCK_IN            : padded block, W[0] in [511:480]
//   IV_IN               : initial chaining value, only with SHA1_IV_LOAD_EN defined
//   BUSY                : block in flight
//   DONE                : one-cycle pulse, DIGEST_OUT newly valid
//   DIGEST_OUT          : {H0..H4}, held until the next DONE
// Build option: SHA1_IV_LOAD_EN adds IV_IN; IN_FIRST then loads H from IV_IN instead
// of the standard IV.
module sha1_stream_core
  import sha1_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic         IN_FIRST,
  input  logic         IN_LAST,
  input  logic [511:0] BLOCK_IN,
`ifdef SHA1_IV_LOAD_EN
  input  logic [159:0] IV_IN,
`endif
  output logic         BUSY,
  output logic         DONE,
  output logic [159:0] DIGEST_OUT
);

  localparam int unsigned R     = ROUNDS_PER_CYCLE;
  localparam logic [6:0]  RStep = 7'(ROUNDS_PER_CYCLE);

  if (!(R == 1 || R == 2 || R == 4 || R == 5)) begin : gen_bad_rounds
    $error("sha1_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 5");
  end

  state_e      state_q;
  logic [6:0]  t_q;
  logic [31:0] w_q [16];
  logic [31:0] h_q [5];
  logic [31:0] a_q, b_q, c_q, d_q, e_q;
  logic        last_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic [159:0] digest_q;

  // Chaining value selected at the accept edge.
  logic [159:0] iv_bus;
  logic [31:0]  h_sel [5];

`ifdef SHA1_IV_LOAD_EN
  assign iv_bus = IV_IN;
`else
  assign iv_bus = StdIv;
`endif

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      h_sel[i] = IN_FIRST ? iv_bus[159-32*i -: 32] : h_q[i];
    end
  end

  // Message schedule window: w_q[0] is W[t]. The extension holds the R words
  // that enter the window this cycle; later ones may depend on earlier ones.
  logic [31:0] w_ext [16+R];
  logic [31:0] w_d   [16];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_ext[i] = w_q[i];
    end
    for (int j = 0; j < int'(R); j++) begin
      w_ext[16+j] = rotl(w_ext[13+j] ^ w_ext[8+j] ^ w_ext[2+j] ^ w_ext[j], 1);
    end
    for (int i = 0; i < 16; i++) begin
      w_d[i] = w_ext[i+R];
    end
  end

  // Chain of R rounds; stage g applies round t_q + g.
  logic [31:0] ca [R+1];
  logic [31:0] cb [R+1];
  logic [31:0] cc [R+1];
  logic [31:0] cd [R+1];
  logic [31:0] ce [R+1];

  assign ca[0] = a_q;
  assign cb[0] = b_q;
  assign cc[0] = c_q;
  assign cd[0] = d_q;
  assign ce[0] = e_q;

  for (genvar g = 0; g < int'(R); g++) begin : gen_round
    sha1_round u_round (
      .a_i (ca[g]),
      .b_i (cb[g]),
      .c_i (cc[g]),
      .d_i (cd[g]),
      .e_i (ce[g]),
      .w_i (w_q[g]),
      .t_i (t_q + 7'(g)),
      .a_o (ca[g+1]),
      .b_o (cb[g+1]),
      .c_o (cc[g+1]),
      .d_o (cd[g+1]),
      .e_o (ce[g+1])
    );
  end

  // Feed-forward sums for the FINAL update.
  logic [31:0]  h_sum [5];
  logic [159:0] h_sum_bus;

  always_comb begin
    h_sum[0]  = h_q[0] + a_q;
    h_sum[1]  = h_q[1] + b_q;
    h_sum[2]  = h_q[2] + c_q;
    h_sum[3]  = h_q[3] + d_q;
    h_sum[4]  = h_q[4] + e_q;
    h_sum_bus = {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4]};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      t_q      <= 7'd0;
      last_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digest_q <= 160'd0;
      for (int i = 0; i < 5; i++) begin
        h_q[i] <= StdIv[159-32*i -: 32];
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (IN_VALID && ready_q) begin
            for (int i = 0; i < 16; i++) begin
              w_q[i] <= BLOCK_IN[511-32*i -: 32];
            end
            for (int i = 0; i < 5; i++) begin
              h_q[i] <= h_sel[i];
            end
            a_q     <= h_sel[0];
            b_q     <= h_sel[1];
            c_q     <= h_sel[2];
            d_q     <= h_sel[3];
            e_q     <= h_sel[4];
            last_q  <= IN_LAST;
            t_q     <= 7'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StRound;
          end
        end
        StRound: begin
          for (int i = 0; i < 16; i++) begin
            w_q[i] <= w_d[i];
          end
          a_q <= ca[R];
          b_q <= cb[R];
          c_q <= cc[R];
          d_q <= cd[R];
          e_q <= ce[R];
          t_q <= t_q + RStep;
          if (t_q + RStep == 7'd80) begin
            state_q <= StFinal;
          end
        end
        StFinal: begin
          for (int i = 0; i < 5; i++) begin
            h_q[i] <= h_sum[i];
          end
          if (last_q) begin
            digest_q <= h_sum_bus;
            done_q   <= 1'b1;
          end
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign IN_READY   = ready_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign DIGEST_OUT = digest_q;

endmodule

// File: tb/tb_sha1_stream_core.sv
// Self-checking bench for sha1_stream_core. Four instances (1, 2, 4 and 5 rounds
// per cycle) are driven independently and compared against known digests and a
// plain SHA-1 reference model. Honours SHA1_IV_LOAD_EN when defined.
module tb_sha1_stream_core;

  localparam logic [159:0] STD_IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                     32'h10325476, 32'hC3D2E1F0};
`ifdef SHA1_IV_LOAD_EN
  localparam bit IvMode = 1'b1;
`else
  localparam bit IvMode = 1'b0;
`endif

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'd0, 64'h18};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'd0};
  localparam logic [511:0] TWO_B1    = {32'h61626364, 32'h62636465, 32'h63646566,
                                        32'h64656667, 32'h65666768, 32'h66676869,
                                        32'h6768696a, 32'h68696a6b, 32'h696a6b6c,
                                        32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000,
                                        32'h00000000};
  localparam logic [511:0] TWO_B2    = {448'd0, 64'h1c0};
  localparam logic [159:0] ABC_DIG   = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
  localparam logic [159:0] EMPTY_DIG = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
  localparam logic [159:0] TWO_DIG   = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid [4];
  logic         in_first [4];
  logic         in_last  [4];
  logic [511:0] block_in [4];
`ifdef SHA1_IV_LOAD_EN
  logic [159:0] iv_in    [4];
`endif
  logic         in_ready [4];
  logic         busy     [4];
  logic         done     [4];
  logic [159:0] digest   [4];

  int           cyc = 0;
  int           done_cnt [4] = '{0, 0, 0, 0};
  int           errors = 0;
  int           checks = 0;
  logic [159:0] mh [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (done[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int unsigned RP = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 5;
    sha1_stream_core #(.ROUNDS_PER_CYCLE(RP)) u_dut (
      .CLK        (clk),
      .RST        (rst),
      .IN_VALID   (in_valid[g]),
      .IN_READY   (in_ready[g]),
      .IN_FIRST   (in_first[g]),
      .IN_LAST    (in_last[g]),
      .BLOCK_IN   (block_in[g]),
`ifdef SHA1_IV_LOAD_EN
      .IV_IN      (iv_in[g]),
`endif
      .BUSY       (busy[g]),
      .DONE       (done[g]),
      .DIGEST_OUT (digest[g])
    );
  end

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    logic [63:0] dbl;
    dbl = {x, x} << n;
    return dbl[63:32];
  endfunction

  // Straightforward SHA-1 compression over a full 80-word schedule.
  function automatic logic [159:0] compress(input logic [159:0] hin, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 80; t++) w[t] = rol(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
    for (int t = 0; t < 80; t++) begin
      case (t / 20)
        0:       begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
        1:       begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
        2:       begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
        default: begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      endcase
      tmp = rol(a, 5) + f + e + k + w[t];
      e = d; d = c; c = rol(b, 30); b = a; a = tmp;
    end
    return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  function automatic int lat(input int k);
    case (k)
      0:       return 81;
      1:       return 41;
      2:       return 21;
      default: return 17;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge that
  // follows the accepting rising edge, with acc = cycle number of that edge.
  task automatic send(input int k, input logic [511:0] blk, input bit first, input bit last,
                      input logic [159:0] iv, output int acc);
    int n;
    n = 0;
    in_valid[k] = 1'b1;
    block_in[k] = blk;
    in_first[k] = first;
    in_last[k]  = last;
`ifdef SHA1_IV_LOAD_EN
    iv_in[k]    = iv;
`endif
    while (in_ready[k] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("accept_timeout", 160'(n), 160'd0);
    acc = cyc + 1;
    @(negedge clk);
    in_valid[k] = 1'b0;
    for (int j = 0; j < 16; j++) block_in[k][511-32*j -: 32] = $urandom;
    if (first) mh[k] = IvMode ? iv : STD_IV;
    mh[k] = compress(mh[k], blk);
  endtask

  task automatic wait_done(input int k, input string tag, input logic [159:0] exp,
                           input int acc);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (done[k] !== 1'b1 && n < 300) begin
      if (in_ready[k] !== 1'b0 || busy[k] !== 1'b1) bad++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 160'(n < 300), 160'd1);
    chk({tag, "_digest"}, digest[k], exp);
    chk({tag, "_latency"}, 160'(cyc - acc), 160'(lat(k)));
    chk({tag, "_busy_ready_in_flight"}, 160'(bad), 160'd0);
    chk({tag, "_ready_busy_at_done"}, {158'd0, in_ready[k], busy[k]}, 160'b10);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 160'(done[k]), 160'd0);
    chk({tag, "_digest_held"}, digest[k], exp);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          acc;
    int          acc2;
    int          dc;
    logic [511:0] blk;
    logic [159:0] ivr;
    bit          first;
    bit          last;

    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; in_first[k] = 1'b0; in_last[k] = 1'b0; block_in[k] = '0;
`ifdef SHA1_IV_LOAD_EN
      iv_in[k] = '0;
`endif
      mh[k] = STD_IV;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_outputs", {157'd0, in_ready[k], busy[k], done[k]}, 160'd0);
      chk("reset_digest", digest[k], 160'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk("ready_after_reset", 160'(in_ready[k]), 160'd1);

    // Known vectors on every rounds-per-cycle variant.
    for (int k = 0; k < 4; k++) begin
      send(k, ABC_BLK, 1'b1, 1'b1, STD_IV, acc);
      wait_done(k, "abc", ABC_DIG, acc);
      send(k, EMPTY_BLK, 1'b1, 1'b1, STD_IV, acc);
      wait_done(k, "empty", EMPTY_DIG, acc);
      dc = done_cnt[k];
      send(k, TWO_B1, 1'b1, 1'b0, STD_IV, acc);
      send(k, TWO_B2, 1'b0, 1'b1, STD_IV, acc2);
      chk("two_block_throughput", 160'(acc2 - acc), 160'(lat(k) + 1));
      chk("two_block_no_early_done", 160'(done_cnt[k] - dc), 160'd0);
      wait_done(k, "two_block", TWO_DIG, acc2);
      chk("two_block_one_done", 160'(done_cnt[k] - dc), 160'd1);
    end

    // Random blocks, random message boundaries and continuation after LAST.
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 6; b++) begin
        for (int j = 0; j < 16; j++) blk[511-32*j -: 32] = $urandom;
        for (int j = 0; j < 5; j++) ivr[159-32*j -: 32] = $urandom;
        first = (b == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
        last  = 1'($urandom_range(0, 1));
        send(k, blk, first, last, ivr, acc);
        if (last) wait_done(k, "random", mh[k], acc);
      end
    end
    repeat (100) @(negedge clk);

    // Abort a block at round 40, then continue without IN_FIRST: H must be the IV.
    for (int j = 0; j < 16; j++) blk[511-32*j -: 32] = $urandom;
    send(0, blk, 1'b1, 1'b1, STD_IV, acc);
    repeat (39) @(negedge clk);
    dc = done_cnt[0];
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {157'd0, in_ready[0], busy[0], done[0]}, 160'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mh[k] = STD_IV;
      chk("abort_digest_cleared", digest[k], 160'd0);
    end
    repeat (120) @(negedge clk);
    chk("abort_no_done", 160'(done_cnt[0] - dc), 160'd0);
    send(0, ABC_BLK, 1'b0, 1'b1, STD_IV, acc);
    wait_done(0, "abc_after_abort", ABC_DIG, acc);

`ifdef SHA1_IV_LOAD_EN
    // Midstate resume: capture H after block 1, feed it back as IV for block 2.
    for (int k = 0; k < 4; k++) begin
      send(k, TWO_B1, 1'b1, 1'b1, STD_IV, acc);
      ivr = mh[k];
      wait_done(k, "midstate_capture", ivr, acc);
      send(k, TWO_B2, 1'b1, 1'b1, ivr, acc);
      wait_done(k, "midstate_resume", TWO_DIG, acc);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
